fpu_exec_sequencer: RTL and testbench

FPU_EXEC_SEQUENCER -- requirements
Module: fpu_exec_sequencer

---
 rtl/fpu_exec_sequencer.sv | 119 +++++++++++
 tb/tb_fpu_exec_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fpu_exec_sequencer.sv
// rtl/fpu_exec_sequencer.sv - issue/run/writeback sequencer around one FPU exec element
// Holds the element in reset outside RUN so every operation starts from a clean completed flag.
`timescale 1ns/1ps
module fpu_exec_sequencer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [5:0]  issue_inst_num,
  input  logic [31:0] issue_fs,
  input  logic [31:0] issue_ft,
  input  logic [4:0]  issue_fd,
  output logic        elem_reset,
  output logic [5:0]  elem_inst_num,
  output logic [31:0] elem_fs,
  output logic [31:0] elem_ft,
  input  logic        elem_completed,
  input  logic [31:0] elem_out,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_fd,
  output logic [31:0] wb_data,
  output logic        wb_timeout,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WB} state_t;

  // Counter holds the number of RUN cycles already spent; abort fires in the one after the last allowed.
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_count;
  logic        r_elem_reset;
  logic [5:0]  r_elem_inst_num;
  logic [31:0] r_elem_fs;
  logic [31:0] r_elem_ft;
  logic        r_wb_valid;
  logic [4:0]  r_wb_fd;
  logic [31:0] r_wb_data;
  logic        r_wb_timeout;

  logic w_accept;
  logic w_done;
  logic w_expire;
  logic w_release;

  assign w_accept  = (r_state == S_IDLE) && issue_valid;
  assign w_done    = (r_state == S_RUN) && elem_completed;
  assign w_expire  = (r_state == S_RUN) && !elem_completed && (r_count == TIMEOUT_LIMIT);
  assign w_release = (r_state == S_WB) && wb_ready;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (w_done || w_expire) w_next = S_WB;
      S_WB:    if (w_release) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    issue_ready = (r_state == S_IDLE);
    busy        = (r_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count         <= 8'd0;
      r_elem_reset    <= 1'b1;
      r_elem_inst_num <= 6'd0;
      r_elem_fs       <= 32'd0;
      r_elem_ft       <= 32'd0;
      r_wb_valid      <= 1'b0;
      r_wb_fd         <= 5'd0;
      r_wb_data       <= 32'd0;
      r_wb_timeout    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_elem_inst_num <= issue_inst_num;
        r_elem_fs       <= issue_fs;
        r_elem_ft       <= issue_ft;
        r_wb_fd         <= issue_fd;
        r_count         <= 8'd0;
      end else if ((r_state == S_RUN) && !elem_completed) begin
        r_count <= r_count + 8'd1;
      end
      // Completion takes priority over the abort when both land in the same cycle.
      if (w_done) begin
        r_wb_data    <= elem_out;
        r_wb_timeout <= 1'b0;
      end else if (w_expire) begin
        r_wb_data    <= 32'd0;
        r_wb_timeout <= 1'b1;
      end
      r_elem_reset <= (w_next != S_RUN);
      r_wb_valid   <= (w_next == S_WB);
    end
  end

  assign elem_reset    = r_elem_reset;
  assign elem_inst_num = r_elem_inst_num;
  assign elem_fs       = r_elem_fs;
  assign elem_ft       = r_elem_ft;
  assign wb_valid      = r_wb_valid;
  assign wb_fd         = r_wb_fd;
  assign wb_data       = r_wb_data;
  assign wb_timeout    = r_wb_timeout;

endmodule

// File: tb/tb_fpu_exec_sequencer.sv
// tb/tb_fpu_exec_sequencer.sv - directed vector bench for fpu_exec_sequencer
// A mock element completes a fixed number of cycles after leaving reset and returns a preset result.
`timescale 1ns/1ps
module tb_fpu_exec_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  logic [5:0]  issue_inst_num;
  logic [31:0] issue_fs;
  logic [31:0] issue_ft;
  logic [4:0]  issue_fd;
  logic        elem_reset;
  logic [5:0]  elem_inst_num;
  logic [31:0] elem_fs;
  logic [31:0] elem_ft;
  logic        elem_completed;
  logic [31:0] elem_out;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_fd;
  logic [31:0] wb_data;
  logic        wb_timeout;
  logic        busy;

  int total = 0;
  int bad   = 0;

  int          m_lat   = 0;
  int          m_cyc   = 0;
  logic        m_done  = 1'b0;
  logic        m_force = 1'b0;
  logic [31:0] m_res   = 32'd0;

  fpu_exec_sequencer #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_inst_num(issue_inst_num), .issue_fs(issue_fs), .issue_ft(issue_ft), .issue_fd(issue_fd),
    .elem_reset(elem_reset), .elem_inst_num(elem_inst_num), .elem_fs(elem_fs), .elem_ft(elem_ft),
    .elem_completed(elem_completed), .elem_out(elem_out),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_fd(wb_fd), .wb_data(wb_data),
    .wb_timeout(wb_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Mock element: lat==0 means it never completes.
  always @(posedge clk) begin
    if (elem_reset) begin
      m_cyc  <= 0;
      m_done <= 1'b0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_lat != 0 && m_cyc + 1 == m_lat) m_done <= 1'b1;
    end
  end
  assign elem_completed = m_done | m_force;
  assign elem_out       = m_res;

  typedef struct {
    logic [5:0]  inst;
    logic [31:0] fs;
    logic [31:0] ft;
    logic [4:0]  fd;
    int          lat;
    logic [31:0] res;
    int          edge_n;
    logic [31:0] exp_data;
    logic        exp_to;
    int          hold;
    bit          intrude;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Entered and left at a negedge; one IDLE cycle separates consecutive calls.
  task automatic run_op(input vec_t v);
    int k;
    bit ok;
    chk("issue_ready_idle", issue_ready, 1);
    issue_valid    = 1'b1;
    issue_inst_num = v.inst;
    issue_fs       = v.fs;
    issue_ft       = v.ft;
    issue_fd       = v.fd;
    m_lat          = v.lat;
    m_res          = v.res;
    wb_ready       = 1'b0;
    @(negedge clk);
    chk("elem_reset_run", elem_reset, 0);
    chk("busy_run", busy, 1);
    chk("issue_ready_run", issue_ready, 0);
    if (v.intrude) begin
      issue_inst_num = ~v.inst;
      issue_fs       = ~v.fs;
      issue_ft       = ~v.ft;
      issue_fd       = ~v.fd;
    end else begin
      issue_valid = 1'b0;
    end
    ok = 1'b1;
    k  = 0;
    while (wb_valid !== 1'b1 && k < 300) begin
      if (elem_inst_num !== v.inst || elem_fs !== v.fs || elem_ft !== v.ft || elem_reset !== 1'b0)
        ok = 1'b0;
      @(negedge clk);
      k++;
    end
    chk("elem_stable", ok, 1);
    chk("wb_edge", k, v.edge_n);
    chk("wb_data", wb_data, v.exp_data);
    chk("wb_fd", wb_fd, v.fd);
    chk("wb_timeout", wb_timeout, v.exp_to);
    chk("elem_reset_wb", elem_reset, 1);
    ok = 1'b1;
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      if (wb_valid !== 1'b1 || wb_data !== v.exp_data || wb_fd !== v.fd ||
          wb_timeout !== v.exp_to || issue_ready !== 1'b0)
        ok = 1'b0;
    end
    chk("wb_hold", ok, 1);
    wb_ready = 1'b1;
    chk("issue_ready_handshake", issue_ready, 0);
    @(negedge clk);
    wb_ready    = 1'b0;
    issue_valid = 1'b0;
    chk("wb_valid_drop", wb_valid, 0);
    chk("busy_after_wb", busy, 0);
    chk("elem_reset_after_wb", elem_reset, 1);
  endtask

  initial begin
    bit ok;
    //           inst   fs            ft            fd  lat res           edge data          to hold intr
    vecs[0] = '{6'd55, 32'h3F800000, 32'h00000000, 5'd3,  1, 32'hBF800000,  2, 32'hBF800000, 0, 0, 0};
    vecs[1] = '{6'd54, 32'h3F800000, 32'h40000000, 5'd7,  3, 32'h40400000,  4, 32'h40400000, 0, 5, 0};
    vecs[2] = '{6'd63, 32'h40800000, 32'h00000000, 5'd9,  0, 32'h55555555, 65, 32'h00000000, 1, 0, 0};
    vecs[3] = '{6'd62, 32'h12345678, 32'h00000000, 5'd12, 64, 32'hCAFEF00D, 65, 32'hCAFEF00D, 0, 0, 0};
    vecs[4] = '{6'd61, 32'h87654321, 32'h11111111, 5'd13, 63, 32'h0BADBEEF, 64, 32'h0BADBEEF, 0, 1, 0};
    vecs[5] = '{6'd56, 32'h40000000, 32'h40400000, 5'd14, 4, 32'h40C00000,  5, 32'h40C00000, 0, 2, 1};
    vecs[6] = '{6'd5,  32'hA5A5A5A5, 32'h5A5A5A5A, 5'd31, 2, 32'h00000001,  3, 32'h00000001, 0, 0, 0};
    vecs[7] = '{6'd57, 32'hBF800000, 32'h00000000, 5'd0,  1, 32'h3F800000,  2, 32'h3F800000, 0, 0, 0};

    reset          = 1'b1;
    issue_valid    = 1'b1;
    issue_inst_num = 6'd60;
    issue_fs       = 32'hDEADBEEF;
    issue_ft       = 32'hFEEDFACE;
    issue_fd       = 5'd21;
    wb_ready       = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_timeout", wb_timeout, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_fd", wb_fd, 0);
    chk("rst_elem_reset", elem_reset, 1);
    chk("rst_elem_inst", elem_inst_num, 0);
    chk("rst_elem_fs", elem_fs, 0);
    chk("rst_elem_ft", elem_ft, 0);
    chk("rst_busy", busy, 0);
    chk("rst_issue_ready", issue_ready, 1);

    reset = 1'b0;
    for (int i = 0; i < 8; i++) run_op(vecs[i]);

    // Reset in the middle of a long DIV.S, then a stray completion while idle.
    chk("div_issue_ready", issue_ready, 1);
    issue_valid    = 1'b1;
    issue_inst_num = 6'd59;
    issue_fs       = 32'h40A00000;
    issue_ft       = 32'h40000000;
    issue_fd       = 5'd17;
    m_lat          = 10;
    m_res          = 32'h40200000;
    @(negedge clk);
    issue_valid = 1'b0;
    chk("div_busy", busy, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrun_busy", busy, 0);
    chk("midrun_elem_reset", elem_reset, 1);
    chk("midrun_wb_valid", wb_valid, 0);
    chk("midrun_elem_fs", elem_fs, 0);
    chk("midrun_wb_fd", wb_fd, 0);
    m_force = 1'b1;
    ok = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (wb_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    m_force = 1'b0;
    chk("stray_completion_ignored", ok, 1);

    run_op(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
